// File: rtl/button_debounce_bank.sv
// Bank of independent push-button debouncers. Each channel synchronises its
// raw input, accepts a level change only after DEBOUNCE_CYC consecutive
// stable synchronised cycles, and emits registered press/release pulses
// plus an optional auto-repeat pulse train while the button stays held.
// Per-channel state lives in ch[i].state_q for observation by checkers.
module button_debounce_bank #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYC    = 5000000,
    parameter int SYNC_STAGES     = 2,
    parameter int REPEAT_DLY_CYC  = 50000000,
    parameter int REPEAT_RATE_CYC = 10000000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N_CH-1:0] btn_i,
    output logic [N_CH-1:0] level_o,
    output logic [N_CH-1:0] press_o,
    output logic [N_CH-1:0] release_o,
    output logic [N_CH-1:0] repeat_o
);

    // Debounce counter only needs to reach DEBOUNCE_CYC and then saturates.
    localparam int DCW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DCW-1:0] DEB_LIM = DCW'(DEBOUNCE_CYC);
    localparam logic [DCW-1:0] DEB_ONE = DCW'(1);
    // With a one-cycle debounce the first stable sample already qualifies.
    localparam bit DEB_IMMEDIATE = (DEBOUNCE_CYC <= 1);

    // Repeat counter is reloaded after every pulse, so it must hold the
    // larger of the initial delay and the repeat period.
    localparam int RPT_MAX = (REPEAT_DLY_CYC > REPEAT_RATE_CYC) ? REPEAT_DLY_CYC
                                                                : REPEAT_RATE_CYC;
    localparam int RCW = $clog2(RPT_MAX + 1);
    localparam logic [RCW-1:0] DLY_LIM  = RCW'(REPEAT_DLY_CYC);
    localparam logic [RCW-1:0] RATE_LIM = RCW'(REPEAT_RATE_CYC);
    localparam bit RPT_EN = (REPEAT_DLY_CYC != 0);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } state_e;

    for (genvar i = 0; i < N_CH; i++) begin : ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   sync;

        state_e         state_q, state_d;
        logic [DCW-1:0] cnt_q, cnt_d, cnt_inc;
        logic [RCW-1:0] rpt_q, rpt_d, rpt_inc, rpt_tgt;
        logic           phase_q, phase_d;   // 0: waiting initial delay, 1: repeating
        logic           level_q, level_d;
        logic           press_q, press_d;
        logic           rel_q, rel_d;
        logic           rep_q, rep_d;

        assign sync    = sync_q[SYNC_STAGES-1];
        assign cnt_inc = (cnt_q == DEB_LIM) ? cnt_q : cnt_q + 1'b1;
        assign rpt_inc = rpt_q + 1'b1;
        assign rpt_tgt = phase_q ? RATE_LIM : DLY_LIM;

        // Shift the raw button level through the synchroniser chain.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i[i]};
            end
        end

        // Register FSM state, counters and all outputs.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                rpt_q   <= '0;
                phase_q <= 1'b0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                rep_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rpt_q   <= rpt_d;
                phase_q <= phase_d;
                level_q <= level_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                rep_q   <= rep_d;
            end
        end

        // Next-state logic: debounce both edges, generate pulses and repeats.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rpt_d   = rpt_q;
            phase_d = phase_q;
            level_d = level_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            rep_d   = 1'b0;

            case (state_q)
                IDLE: begin
                    if (sync) begin
                        if (DEB_IMMEDIATE) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            level_d = 1'b1;
                            press_d = 1'b1;
                            rpt_d   = '0;
                            phase_d = 1'b0;
                        end else begin
                            state_d = PRESS_CNT;
                            cnt_d   = DEB_ONE;
                        end
                    end
                end
                PRESS_CNT: begin
                    if (!sync) begin
                        // Glitch shorter than the debounce window: drop it.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc >= DEB_LIM) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                        rpt_d   = '0;
                        phase_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        if (DEB_IMMEDIATE) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            level_d = 1'b0;
                            rel_d   = 1'b1;
                            rpt_d   = '0;
                            phase_d = 1'b0;
                        end else begin
                            state_d = REL_CNT;
                            cnt_d   = DEB_ONE;
                        end
                    end else if (RPT_EN) begin
                        // Count held cycles; pulse and reload on each target hit.
                        if (rpt_inc == rpt_tgt) begin
                            rep_d   = 1'b1;
                            rpt_d   = '0;
                            phase_d = 1'b1;
                        end else begin
                            rpt_d = rpt_inc;
                        end
                    end
                end
                REL_CNT: begin
                    if (sync) begin
                        // Release glitch: resume holding, repeat timing untouched.
                        state_d = HELD;
                        cnt_d   = '0;
                    end else if (cnt_inc >= DEB_LIM) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        level_d = 1'b0;
                        rel_d   = 1'b1;
                        rpt_d   = '0;
                        phase_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign level_o[i]   = level_q;
        assign press_o[i]   = press_q;
        assign release_o[i] = rel_q;
        assign repeat_o[i]  = rep_q;
    end

endmodule

// File: tb/tb_button_debounce_bank.sv
// Directed bench for button_debounce_bank with a 2-channel, short-timing
// configuration. Inputs change on the falling edge; outputs are sampled on
// the falling edge, so "after edge k" is the (k+1)-th falling edge after
// the stimulus change.
module tb_button_debounce_bank;

    localparam int N_CH = 2;

    logic            clk_i;
    logic            rst_i;
    logic [N_CH-1:0] btn_i;
    logic [N_CH-1:0] level_o;
    logic [N_CH-1:0] press_o;
    logic [N_CH-1:0] release_o;
    logic [N_CH-1:0] repeat_o;

    int checks;
    int failures;

    button_debounce_bank #(
        .N_CH           (2),
        .DEBOUNCE_CYC   (4),
        .SYNC_STAGES    (2),
        .REPEAT_DLY_CYC (10),
        .REPEAT_RATE_CYC(3)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .btn_i    (btn_i),
        .level_o  (level_o),
        .press_o  (press_o),
        .release_o(release_o),
        .repeat_o (repeat_o)
    );

    // Clock and reset
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        btn_i = '0;
        idle_cycles(3);
        checks++;
        if ({level_o, press_o, release_o, repeat_o} !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=00", {level_o, press_o, release_o, repeat_o});
        end
        rst_i = 1'b0;
        idle_cycles(4);
        checks++;
        if ({level_o, press_o, release_o, repeat_o} !== 8'h00) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=00", {level_o, press_o, release_o, repeat_o});
        end
    endtask

    // Press on channel 0: press pulse and level after edge 5, channel 1 quiet.
    task automatic test_press();
        btn_i = 2'b01;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_i);
            checks++;
            if (press_o !== ((j == 5) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL press_pulse edge=%0d got=%b exp=%b", j, press_o, (j == 5) ? 2'b01 : 2'b00);
            end
            checks++;
            if (level_o !== ((j >= 5) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL press_level edge=%0d got=%b exp=%b", j, level_o, (j >= 5) ? 2'b01 : 2'b00);
            end
            checks++;
            if (release_o !== 2'b00) begin
                failures++;
                $display("FAIL press_no_release edge=%0d got=%b exp=00", j, release_o);
            end
        end
    endtask

    // While held: 2-cycle low glitch is ignored, then a clean release.
    task automatic test_release();
        btn_i = 2'b00;
        idle_cycles(2);
        btn_i = 2'b01;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk_i);
            checks++;
            if (release_o !== 2'b00 || level_o !== 2'b01) begin
                failures++;
                $display("FAIL glitch_while_held cyc=%0d rel=%b lvl=%b exp rel=00 lvl=01", j, release_o, level_o);
            end
        end
        btn_i = 2'b00;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_i);
            checks++;
            if (release_o !== ((j == 5) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL release_pulse edge=%0d got=%b exp=%b", j, release_o, (j == 5) ? 2'b01 : 2'b00);
            end
            checks++;
            if (level_o !== ((j < 5) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL release_level edge=%0d got=%b exp=%b", j, level_o, (j < 5) ? 2'b01 : 2'b00);
            end
        end
    endtask

    // Short presses and toggling never reach the debounce threshold.
    task automatic test_glitch_reject();
        btn_i = 2'b01;
        idle_cycles(3);
        btn_i = 2'b00;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk_i);
            checks++;
            if ({level_o, press_o, release_o, repeat_o} !== 8'h00) begin
                failures++;
                $display("FAIL short_press cyc=%0d got=%h exp=00", j, {level_o, press_o, release_o, repeat_o});
            end
        end
        for (int j = 0; j < 20; j++) begin
            btn_i = ((j / 2) % 2 == 0) ? 2'b01 : 2'b00;
            @(negedge clk_i);
            checks++;
            if ({level_o, press_o, release_o, repeat_o} !== 8'h00) begin
                failures++;
                $display("FAIL toggle cyc=%0d got=%h exp=00", j, {level_o, press_o, release_o, repeat_o});
            end
        end
        btn_i = 2'b00;
        idle_cycles(6);
    endtask

    // Held button: repeat at 10 cycles after press, then every 3 cycles.
    task automatic test_repeat();
        logic [1:0] exp_rep;
        int         d;
        btn_i = 2'b01;
        for (int j = 0; j < 36; j++) begin
            @(negedge clk_i);
            d = j - 5;
            exp_rep = (d >= 10 && ((d - 10) % 3) == 0) ? 2'b01 : 2'b00;
            checks++;
            if (repeat_o !== exp_rep) begin
                failures++;
                $display("FAIL repeat d=%0d got=%b exp=%b", d, repeat_o, exp_rep);
            end
            if (j == 5) begin
                checks++;
                if (press_o !== 2'b01) begin
                    failures++;
                    $display("FAIL repeat_press got=%b exp=01", press_o);
                end
            end
        end
        btn_i = 2'b00;
        idle_cycles(8);
        checks++;
        if ({level_o, repeat_o} !== 4'h0) begin
            failures++;
            $display("FAIL repeat_released got=%h exp=0", {level_o, repeat_o});
        end
    endtask

    // Both channels pressed together, then reset while held.
    task automatic test_back_to_back();
        btn_i = 2'b11;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk_i);
            checks++;
            if (press_o !== ((j == 5) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL dual_press edge=%0d got=%b exp=%b", j, press_o, (j == 5) ? 2'b11 : 2'b00);
            end
        end
        checks++;
        if (level_o !== 2'b11) begin
            failures++;
            $display("FAIL dual_level got=%b exp=11", level_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if ({level_o, press_o, release_o, repeat_o} !== 8'h00) begin
            failures++;
            $display("FAIL async_reset got=%h exp=00", {level_o, press_o, release_o, repeat_o});
        end
        idle_cycles(2);
        checks++;
        if ({level_o, release_o} !== 4'h0) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=0", {level_o, release_o});
        end
        rst_i = 1'b0;
        for (int j = 0; j < 7; j++) begin
            @(negedge clk_i);
            checks++;
            if (press_o !== ((j == 5) ? 2'b11 : 2'b00)) begin
                failures++;
                $display("FAIL repress edge=%0d got=%b exp=%b", j, press_o, (j == 5) ? 2'b11 : 2'b00);
            end
            checks++;
            if (release_o !== 2'b00) begin
                failures++;
                $display("FAIL repress_no_release edge=%0d got=%b exp=00", j, release_o);
            end
        end
        btn_i = 2'b00;
        idle_cycles(8);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_i    = 1'b1;
        btn_i    = '0;
        @(negedge clk_i);
        test_reset();
        test_press();
        test_release();
        test_glitch_reject();
        test_repeat();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debounce_bank.md
BUTTON_DEBOUNCE_BANK -- requirements
Module: button_debounce_bank

Interface
REQ-001 Parameter N_CH, default 4, number of independent button channels (1..16) SHALL be supported.
REQ-002 Parameter DEBOUNCE_CYC, default 5000000, consecutive stable synchronised cycles required to accept a transition (>=1).
REQ-003 Parameter SYNC_STAGES, default 2, synchroniser flop count per channel (>=2).
REQ-004 Parameter REPEAT_DLY_CYC, default 50000000, cycles from press pulse to first repeat pulse; 0 disables auto-repeat.
REQ-005 Parameter REPEAT_RATE_CYC, default 10000000, cycles between subsequent repeat pulses (>=1).
REQ-006 clk_i  input  1  system clock, all logic on rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 btn_i  input  N_CH  raw asynchronous button levels, 1 = pressed.
REQ-009 level_o  output  N_CH  debounced button level.
REQ-010 press_o  output  N_CH  one-cycle pulse on accepted press.
REQ-011 release_o  output  N_CH  one-cycle pulse on accepted release.
REQ-012 repeat_o  output  N_CH  one-cycle auto-repeat pulse while held.

Function
REQ-013 Each channel SHALL pass btn_i through SYNC_STAGES flops; all further logic SHALL use only the synchronised value (sync).
REQ-014 Channels SHALL be fully independent; simultaneous events on several channels SHALL each be handled in the same cycle.
REQ-015 Per-channel FSM states SHALL be IDLE, PRESS_CNT, HELD, REL_CNT.
REQ-016 IDLE: sync=1 -> PRESS_CNT with debounce counter cleared and counting that cycle as 1.
REQ-017 PRESS_CNT: sync=0 -> IDLE, no output (glitch rejected); sync=1 with count reaching DEBOUNCE_CYC -> HELD.
REQ-018 HELD: sync=0 -> REL_CNT with counter restarted at 1.
REQ-019 REL_CNT: sync=1 -> HELD, no output, repeat timing unaffected; sync=0 with count reaching DEBOUNCE_CYC -> IDLE.
REQ-020 Entry to HELD from PRESS_CNT SHALL set level_o=1 and assert press_o for exactly one cycle, in the same registered update.
REQ-021 Entry to IDLE from REL_CNT SHALL clear level_o and assert release_o for exactly one cycle.
REQ-022 Latency: btn_i first sampled high at edge 0 and held stable -> level_o/press_o visible after edge SYNC_STAGES+DEBOUNCE_CYC-1; release symmetric.
REQ-023 Any sync pulse shorter than DEBOUNCE_CYC cycles SHALL produce no change on any output.
REQ-024 Debounce counter width SHALL be $clog2(DEBOUNCE_CYC+1); counter SHALL saturate, never wrap.
REQ-025 Repeat counter SHALL clear on press, increment only in HELD, hold in REL_CNT, clear on entry to IDLE.
REQ-026 repeat_o SHALL pulse when repeat count reaches REPEAT_DLY_CYC, then every REPEAT_RATE_CYC cycles in HELD; never in the press_o cycle.
REQ-027 With REPEAT_DLY_CYC=0, repeat_o SHALL stay 0 permanently.
REQ-028 press_o, release_o and repeat_o SHALL be registered; no output SHALL depend combinationally on btn_i.

Reset
REQ-029 rst_i=1 SHALL immediately force all synchroniser flops, counters and outputs to 0 and all FSMs to IDLE.
REQ-030 Reset asserted mid-debounce or mid-hold SHALL emit no release_o; after deassertion a still-held button SHALL be treated as a new press (full debounce, then press_o).
REQ-031 First state change after rst_i deassertion SHALL occur on the following rising clk_i edge.

Verification (N_CH=2, SYNC_STAGES=2, DEBOUNCE_CYC=4, REPEAT_DLY_CYC=10, REPEAT_RATE_CYC=3)
REQ-032 btn_i[0] rises before edge 0, held -> level_o[0]=1 and press_o[0]=1 for one cycle after edge 5; channel 1 outputs stay 0.
REQ-033 btn_i[0] high for 3 cycles then low -> no press_o, level_o stays 0; repeated 1-0-1 toggling every 2 cycles -> no output change.
REQ-034 Held channel 0 released cleanly -> release_o[0] one cycle, level_o[0]=0 after edge release_start+5; a 2-cycle low glitch while held -> no release_o.
REQ-035 Channel 0 held 30 cycles after press -> repeat_o[0] pulses 10, 13, 16, 19, 22, 25, 28 cycles after press_o cycle.
REQ-036 Both channels pressed in same cycle -> press_o=2'b11 in one cycle; rst_i pulsed while held -> outputs 0 immediately, no release_o, press_o again 6 edges after reset release.
